mux8_rr_arbiter: RTL and testbench
==================================

// Module: mux8_rr_arbiter
// PURPOSE
//   Shares one 8:1 x W-bit selection path between 8 requesters.
//   Each requester raises req[i] and presents its word on data[i].
//   Round-robin arbitration picks one winner and drives the select code.
//   The winner's word goes into an output register with a valid/ready handshake.
//   Sits between the requesters and a single downstream consumer.
// PARAMETERS
//   W         4   data word width per requester
//   N         8   requester count; fixed at 8 (select is 3 bits)
//   LOCK_MAX  4   max consecutive grants to a locked winner (MUX_ARB_LOCK_EN only)
// PORTS
//   clk        in   1    single clock, rising edge
//   rst_n      in   1    asynchronous active-low reset
//   req        in   8    request per requester; held until its grant pulse
//   data       in   8*W  requester words; data[i*W +: W] belongs to requester i
//   lock       in   8    hold-grant request per requester (present only with MUX_ARB_LOCK_EN)
//   out_ready  in   1    downstream accepts out_data when high
//   out_valid  out  1    out_data/out_sel hold a captured word
//   out_data   out  W    captured word of last winner
//   out_sel    out  3    index of last winner (the 8:1 select code)
//   grant      out  8    one-hot, 1-cycle pulse: winner's data was sampled this edge
// BEHAVIOUR
//   Reset (async assert, sync release):
//     out_valid=0, out_data=0, out_sel=0, grant=0, state=IDLE.
//     Pointer last=7, so req[0] has first priority.
//   FSM has two states:
//     IDLE: out_valid=0.
//     FULL: out_valid=1; out_data/out_sel frozen until handshake.
//   Arbitration is enabled when (state==IDLE) or (out_valid && out_ready).
//   When enabled and |req:
//     - Winner = first set req scanning last+1, last+2, ... mod 8.
//     - On the edge: out_data<=data[winner], out_sel<=winner,
//       grant[winner]=1 for that cycle, last<=winner, state=FULL.
//   When enabled and req==0:
//     - Handshake (if any) completes; state=IDLE, out_valid=0.
//     - out_data and out_sel hold their last values.
//   Latency and throughput:
//     - req high at cycle t (IDLE) -> out_valid high at t+1.
//     - Back-to-back: handshake and new capture share one edge, so 1 word/cycle
//       with out_ready held high.
//   Backpressure: while out_valid && !out_ready, there are no grants and the
//     outputs stay stable. Requesters keep req and data steady.
//   A requester that drops req before its grant is simply skipped; no error.
//   Fairness: with all 8 req high, grants cycle 0,1,...,7,0; no requester waits
//     more than 7 grants.
//   Reset mid-transfer discards the pending word; no grant is issued during reset.
// CONFIGURATION
//   MUX_ARB_LOCK_EN defined:
//     - lock port exists.
//     - If req[last] && lock[last] when arbitration is enabled, last wins again,
//       regardless of rotation, for up to LOCK_MAX consecutive grants.
//     - After LOCK_MAX grants, normal round-robin from last+1 is forced for one
//       arbitration; then the lock count clears.
//     - The lock count also clears on any change of winner.
//   MUX_ARB_LOCK_EN undefined:
//     - lock port and counter are absent.
//     - Pure round-robin as above.
// STRUCTURE
//   Package mux_arb_pkg:
//     - MUX_N=8, MUX_SELW=3, MUX_W=4.
//     - typedef enum {ARB_IDLE, ARB_FULL} arb_state_t.
//   Sub-module rr_pick8 (combinational):
//     - Inputs: req[7:0], last[2:0].
//     - Outputs: any, idx[2:0], onehot[7:0].
//     - Priority rotated to start at last+1.
//   Top level holds the FSM, pointer, output register, W-bit 8:1 word select,
//   and the optional lock counter.
// TESTING
//   1. Reset: rst_n=0 with req=8'hFF
//      -> out_valid=0, out_data=0, out_sel=0, grant=0.
//      Release with req=8'h01, data[0]=4'hA
//      -> next edge: grant=8'h01, out_sel=0, out_data=4'hA, out_valid=1.
//   2. Round-robin: req=8'hFF held, out_ready=1, data[i]=i
//      -> out_sel goes 0,1,...,7,0 on consecutive cycles; out_data follows.
//   3. Backpressure: out_ready=0 for 5 cycles with req=8'h0C
//      -> out_valid=1, out_data frozen, grant=0 during the stall.
//      Raise out_ready -> grant moves to the next requester on the same edge.
//   4. Sparse and rotation: req=8'h81 after last=0
//      -> winner 7, then 0.
//      Drop req entirely after a handshake -> out_valid=0 next cycle.
//   5. Lock (MUX_ARB_LOCK_EN): req=8'h22, lock=8'h02, out_ready=1
//      -> grants 1,1,1,1,5,1,...; the same bench without the macro
//      -> grants 1,5,1,5.
//   6. Async reset asserted while out_valid=1 and out_ready=0
//      -> out_valid=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants and types for the 8-requester round-robin word arbiter.
//   MUX_N       requester count (fixed at 8)
//   MUX_SELW    width of the select code
//   MUX_W       default data word width
//   arb_state_t output-register state (empty / holding a word)
//   sel_to_onehot  converts a select code into an 8-bit one-hot vector
package mux_arb_pkg;

   localparam int MUX_N    = 8;
   localparam int MUX_SELW = 3;
   localparam int MUX_W    = 4;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_FULL = 1'b1
   } arb_state_t;

   function automatic logic [MUX_N-1:0] sel_to_onehot(input logic [MUX_SELW-1:0] sel);
      logic [MUX_N-1:0] one;
      one = {{(MUX_N-1){1'b0}}, 1'b1};
      return one << sel;
   endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational rotating-priority picker for 8 requesters.
// Priority starts at last+1 and wraps, so the previous winner is checked last.
//   req     in   8  request vector
//   last    in   3  index of the previous winner
//   any     out  1  at least one request is set
//   idx     out  3  index of the chosen requester (0 when any=0)
//   onehot  out  8  one-hot form of idx (all zero when any=0)
module rr_pick8
   import mux_arb_pkg::*;
(
   input  logic [MUX_N-1:0]    req,
   input  logic [MUX_SELW-1:0] last,
   output logic                any,
   output logic [MUX_SELW-1:0] idx,
   output logic [MUX_N-1:0]    onehot
);

   logic [2*MUX_N-1:0]  req_dbl;
   logic [MUX_SELW:0]   start;
   logic [MUX_N-1:0]    rotated;
   logic [MUX_SELW-1:0] offset;

   // Rotate the request vector so bit 0 is requester last+1; the lowest set
   // bit of the rotated vector is then the round-robin winner.
   assign req_dbl = {req, req};
   assign start   = {1'b0, last} + 4'd1;
   assign rotated = req_dbl[start +: MUX_N];

   always_comb begin
      offset = '0;
      for (int i = MUX_N - 1; i >= 0; i--) begin
         if (rotated[i]) offset = MUX_SELW'(i);
      end
   end

   // Three-bit add wraps modulo 8; start=8 (last=7) maps back to 0.
   assign any    = |req;
   assign idx    = any ? (start[MUX_SELW-1:0] + offset) : '0;
   assign onehot = any ? sel_to_onehot(idx) : '0;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 x W-bit select path between 8
// requesters, feeding a single output register with a valid/ready handshake.
// Optional feature macro: MUX_ARB_LOCK_EN (adds the lock port and a
// consecutive-grant counter that lets a locked winner keep the path for up
// to LOCK_MAX grants).
//   clk        in   1    rising-edge clock
//   rst_n      in   1    asynchronous active-low reset
//   req        in   N    per-requester request, held until its grant pulse
//   data       in   N*W  requester words, data[i*W +: W] is requester i
//   lock       in   N    per-requester hold-grant request (MUX_ARB_LOCK_EN)
//   out_ready  in   1    downstream accepts the held word
//   out_valid  out  1    out_data/out_sel hold a captured word
//   out_data   out  W    word of the last winner
//   out_sel    out  3    index of the last winner
//   grant      out  N    one-hot pulse: the winner's word was sampled this edge
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ARB_IDLE | output register empty, out_valid=0, arbitration open
// ARB_FULL | output register holds a word, frozen until out_ready
module mux8_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int W        = MUX_W,
   parameter int N        = MUX_N,   // must stay 8: select code is 3 bits
   parameter int LOCK_MAX = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N-1:0]        req,
   input  logic [N*W-1:0]      data,
`ifdef MUX_ARB_LOCK_EN
   input  logic [N-1:0]        lock,
`endif
   input  logic                out_ready,
   output logic                out_valid,
   output logic [W-1:0]        out_data,
   output logic [MUX_SELW-1:0] out_sel,
   output logic [N-1:0]        grant
);

   arb_state_t          state_q;
   logic [MUX_SELW-1:0] last_q;

   logic                arb_en;
   logic                pick_any;
   logic [MUX_SELW-1:0] pick_idx;
   logic [N-1:0]        pick_onehot;
   logic [MUX_SELW-1:0] win_idx;
   logic [N-1:0]        win_onehot;
   logic [W-1:0]        win_data;

   assign out_valid = (state_q == ARB_FULL);

   // The held word leaves on the same edge a new one is captured, so a
   // steady out_ready gives one word per cycle.
   assign arb_en = (state_q == ARB_IDLE) || out_ready;

   rr_pick8 u_pick (
      .req    (req),
      .last   (last_q),
      .any    (pick_any),
      .idx    (pick_idx),
      .onehot (pick_onehot)
   );

`ifdef MUX_ARB_LOCK_EN
   localparam int CNT_W = $clog2(LOCK_MAX + 1);

   logic [CNT_W-1:0] lock_cnt_q;
   logic             lock_hold;
   logic             lock_spent;

   // lock_cnt_q counts consecutive grants to last_q. Once it reaches
   // LOCK_MAX the lock is ignored for one arbitration so the others get a turn.
   assign lock_spent = (lock_cnt_q >= CNT_W'(LOCK_MAX));
   assign lock_hold  = req[last_q] && lock[last_q] && !lock_spent;
   assign win_idx    = lock_hold ? last_q : pick_idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_cnt_q <= '0;
      end else if (arb_en && pick_any) begin
         if ((win_idx != last_q) || lock_spent) lock_cnt_q <= CNT_W'(1);
         else                                   lock_cnt_q <= lock_cnt_q + CNT_W'(1);
      end
   end
`else
   assign win_idx = pick_idx;
`endif

   assign win_onehot = sel_to_onehot(win_idx);

   always_comb begin
      win_data = '0;
      for (int i = 0; i < N; i++) begin
         if (win_idx == MUX_SELW'(i)) win_data = data[i*W +: W];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ARB_IDLE;
         last_q   <= MUX_SELW'(N - 1);
         out_data <= '0;
         out_sel  <= '0;
         grant    <= '0;
      end else begin
         grant <= '0;
         if (arb_en) begin
            if (pick_any) begin
               out_data <= win_data;
               out_sel  <= win_idx;
               grant    <= win_onehot;
               last_q   <= win_idx;
               state_q  <= ARB_FULL;
            end else begin
               // Nothing to capture: drop valid but keep the last word/select.
               state_q  <= ARB_IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
module tb_mux8_rr_arbiter;

   localparam int W        = 4;
   localparam int LOCK_MAX = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  req;
   logic [31:0] data;
`ifdef MUX_ARB_LOCK_EN
   logic [7:0]  lock;
`endif
   logic        out_ready;
   logic        out_valid;
   logic [3:0]  out_data;
   logic [2:0]  out_sel;
   logic [7:0]  grant;

   always #5 clk = ~clk;

   mux8_rr_arbiter #(.W(W), .N(8), .LOCK_MAX(LOCK_MAX)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .data      (data),
`ifdef MUX_ARB_LOCK_EN
      .lock      (lock),
`endif
      .out_ready (out_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .grant     (grant)
   );

   typedef struct packed {
      logic       valid;
      logic [3:0] wdata;
      logic [2:0] sel;
      logic [7:0] gnt;
   } obs_t;

   obs_t sb_q[$];
   obs_t mon_exp;
   obs_t mon_act;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   logic       m_valid;
   logic [3:0] m_data;
   logic [2:0] m_sel;
   logic [2:0] m_last;
   int         m_cnt;

   task automatic model_reset();
      m_valid = 1'b0;
      m_data  = '0;
      m_sel   = '0;
      m_last  = 3'd7;
      m_cnt   = 0;
      sb_q.delete();
   endtask

   // Predict the outputs after the coming edge from the inputs now applied.
   task automatic model_edge();
      obs_t       e;
      logic [2:0] w;
      logic       found;
      logic       hold;
      e.gnt = 8'h00;
      if (!m_valid || out_ready) begin
         if (req != 8'h00) begin
            hold = 1'b0;
`ifdef MUX_ARB_LOCK_EN
            hold = req[m_last] && lock[m_last] && (m_cnt < LOCK_MAX);
`endif
            w     = m_last;
            found = 1'b0;
            if (!hold) begin
               for (int k = 1; k <= 8; k++) begin
                  if (!found && req[(int'(m_last) + k) % 8]) begin
                     found = 1'b1;
                     w     = 3'((int'(m_last) + k) % 8);
                  end
               end
            end
`ifdef MUX_ARB_LOCK_EN
            if (w != m_last || m_cnt >= LOCK_MAX) m_cnt = 1;
            else                                  m_cnt = m_cnt + 1;
`endif
            m_data  = data[int'(w)*4 +: 4];
            m_sel   = w;
            m_last  = w;
            m_valid = 1'b1;
            e.gnt   = 8'h01 << w;
         end else begin
            m_valid = 1'b0;
         end
      end
      e.valid = m_valid;
      e.wdata = m_data;
      e.sel   = m_sel;
      sb_q.push_back(e);
   endtask

   // One clock: predict, let the edge happen, then leave time for the monitor.
   task automatic cyc();
      model_edge();
      @(posedge clk);
      #2;
   endtask

   always @(posedge clk) begin
      #1;
      if (sb_q.size() > 0) begin
         mon_exp = sb_q.pop_front();
         mon_act = {out_valid, out_data, out_sel, grant};
         checks++;
         if (mon_act !== mon_exp) begin
            failures++;
            $display("FAIL scoreboard t=%0t got v=%0b d=%h s=%0d g=%h want v=%0b d=%h s=%0d g=%h",
                     $time, mon_act.valid, mon_act.wdata, mon_act.sel, mon_act.gnt,
                     mon_exp.valid, mon_exp.wdata, mon_exp.sel, mon_exp.gnt);
         end
      end
   end

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      req       = 8'hFF;
      data      = 32'h7654_3210;
      out_ready = 1'b0;
      rst_n     = 1'b0;
      model_reset();
      @(posedge clk);
      #2;
      checks++;
      if ({out_valid, out_data, out_sel, grant} !== 16'h0000) begin
         failures++;
         $display("FAIL reset_values got v=%0b d=%h s=%0d g=%h want all zero",
                  out_valid, out_data, out_sel, grant);
      end
      req        = 8'h01;
      data[3:0]  = 4'hA;
      rst_n      = 1'b1;
      cyc();
      checks++;
      if (grant !== 8'h01 || out_sel !== 3'd0 || out_data !== 4'hA || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL first_grant got g=%h s=%0d d=%h v=%0b want g=01 s=0 d=a v=1",
                  grant, out_sel, out_data, out_valid);
      end
      req = 8'h00;
      cyc();
      checks++;
      if (grant !== 8'h00 || out_valid !== 1'b1) begin
         failures++;
         $display("FAIL grant_pulse got g=%h v=%0b want g=00 v=1", grant, out_valid);
      end
   endtask

   task automatic test_round_robin();
      do_reset();
      for (int i = 0; i < 8; i++) data[i*4 +: 4] = 4'(i);
      req       = 8'hFF;
      out_ready = 1'b1;
      for (int k = 0; k < 9; k++) begin
         cyc();
         checks++;
         if (out_sel !== 3'(k % 8) || out_data !== 4'(k % 8) || grant !== (8'h01 << (k % 8))) begin
            failures++;
            $display("FAIL round_robin step %0d got s=%0d d=%h g=%h want s=%0d", k,
                     out_sel, out_data, grant, k % 8);
         end
      end
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 8; i++) data[i*4 +: 4] = 4'(i + 8);
      req       = 8'h0C;
      out_ready = 1'b1;
      cyc();
      checks++;
      if (out_sel !== 3'd2 || out_data !== 4'hA || grant !== 8'h04) begin
         failures++;
         $display("FAIL bp_capture got s=%0d d=%h g=%h want s=2 d=a g=04", out_sel, out_data, grant);
      end
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         cyc();
         checks++;
         if (out_valid !== 1'b1 || out_data !== 4'hA || out_sel !== 3'd2 || grant !== 8'h00) begin
            failures++;
            $display("FAIL bp_stall cycle %0d got v=%0b d=%h s=%0d g=%h want v=1 d=a s=2 g=00",
                     k, out_valid, out_data, out_sel, grant);
         end
      end
      out_ready = 1'b1;
      cyc();
      checks++;
      if (grant !== 8'h08 || out_sel !== 3'd3 || out_data !== 4'hB) begin
         failures++;
         $display("FAIL bp_release got g=%h s=%0d d=%h want g=08 s=3 d=b", grant, out_sel, out_data);
      end
   endtask

   task automatic test_sparse_rotation();
      do_reset();
      data           = 32'h0;
      data[3:0]      = 4'h5;
      data[31:28]    = 4'hC;
      req            = 8'h01;
      out_ready      = 1'b1;
      cyc();
      req = 8'h81;
      cyc();
      checks++;
      if (out_sel !== 3'd7 || out_data !== 4'hC || grant !== 8'h80) begin
         failures++;
         $display("FAIL sparse_first got s=%0d d=%h g=%h want s=7 d=c g=80", out_sel, out_data, grant);
      end
      cyc();
      checks++;
      if (out_sel !== 3'd0 || out_data !== 4'h5 || grant !== 8'h01) begin
         failures++;
         $display("FAIL sparse_wrap got s=%0d d=%h g=%h want s=0 d=5 g=01", out_sel, out_data, grant);
      end
      req = 8'h00;
      cyc();
      checks++;
      if (out_valid !== 1'b0 || grant !== 8'h00 || out_sel !== 3'd0 || out_data !== 4'h5) begin
         failures++;
         $display("FAIL drain got v=%0b g=%h s=%0d d=%h want v=0 g=00 s=0 d=5",
                  out_valid, grant, out_sel, out_data);
      end
   endtask

   task automatic test_lock();
      int exp_sel[10];
`ifdef MUX_ARB_LOCK_EN
      exp_sel = '{1, 1, 1, 1, 5, 1, 1, 1, 1, 5};
`else
      exp_sel = '{1, 5, 1, 5, 1, 5, 1, 5, 1, 5};
`endif
      do_reset();
      data      = 32'h7654_3210;
      req       = 8'h22;
`ifdef MUX_ARB_LOCK_EN
      lock      = 8'h02;
`endif
      out_ready = 1'b1;
      for (int k = 0; k < 10; k++) begin
         cyc();
         checks++;
         if (out_sel !== 3'(exp_sel[k])) begin
            failures++;
            $display("FAIL lock_sequence step %0d got s=%0d want s=%0d", k, out_sel, exp_sel[k]);
         end
      end
`ifdef MUX_ARB_LOCK_EN
      lock = 8'h00;
`endif
   endtask

   task automatic test_random();
      do_reset();
      for (int k = 0; k < 300; k++) begin
         req       = 8'($urandom);
         data      = $urandom;
         out_ready = ($urandom_range(0, 3) != 0);
`ifdef MUX_ARB_LOCK_EN
         lock      = 8'($urandom) | 8'($urandom);
`endif
         cyc();
      end
`ifdef MUX_ARB_LOCK_EN
      lock = 8'h00;
`endif
   endtask

   task automatic test_async_reset();
      do_reset();
      data      = 32'h0000_0009;
      req       = 8'h01;
      out_ready = 1'b0;
      cyc();
      req = 8'h00;
      checks++;
      if (out_valid !== 1'b1) begin
         failures++;
         $display("FAIL async_setup got v=%0b want v=1", out_valid);
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || grant !== 8'h00 || out_data !== 4'h0 || out_sel !== 3'd0) begin
         failures++;
         $display("FAIL async_reset got v=%0b g=%h d=%h s=%0d want all zero",
                  out_valid, grant, out_data, out_sel);
      end
      model_reset();
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n     = 1'b0;
      req       = 8'h00;
      data      = 32'h0;
      out_ready = 1'b0;
`ifdef MUX_ARB_LOCK_EN
      lock      = 8'h00;
`endif
      model_reset();
      @(posedge clk);
      #2;
      test_reset();
      test_round_robin();
      test_backpressure();
      test_sparse_rotation();
      test_lock();
      test_random();
      test_async_reset();
      repeat (2) @(posedge clk);
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
